// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between NUM_REQ requesters.
// Grants one operand pair at a time, routes the product back, and aborts hung multiplies.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [15:0]          rsp_product,
    output logic                 mul_valid,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [15:0]          mul_product,
    input  logic                 mul_done,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] last_grant, grant, pick, cand;
    logic          found;
    logic [7:0]    sel_a, sel_b;
    logic [CW-1:0] cnt;
    logic          timeout_hit;

    // Rotating-priority search starting just after the previous grantee.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i)) begin
                sel_a = req_a[8*i +: 8];
                sel_b = req_b[8*i +: 8];
            end
            req_ready[i] = (state == IDLE) && found && (pick == IW'(i));
            rsp_valid[i] = (state == RESP) && (grant == IW'(i));
        end
    end

    assign mul_valid   = (state == ISSUE);
    assign busy        = (state != IDLE);
    assign timeout_hit = (state == WAIT) && !mul_done && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (mul_done) state_nx = RESP;
                     else if (timeout_hit) state_nx = IDLE;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= IW'(NUM_REQ - 1);
            grant       <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            cnt         <= '0;
            rsp_product <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            timeout_err <= timeout_hit;
            case (state)
                IDLE: if (found) begin
                    mul_a      <= sel_a;
                    mul_b      <= sel_b;
                    grant      <= pick;
                    last_grant <= pick;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done) rsp_product <= mul_product;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a scoreboard queue of expected responses
// is filled by the stimulus and drained by an independent response monitor.
module tb_mult_share_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid, req_ready, rsp_valid;
    logic [N*8-1:0] req_a, req_b;
    logic [15:0]   rsp_product, mul_product;
    logic          mul_valid, mul_done, busy, timeout_err;
    logic [7:0]    mul_a, mul_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int idx; logic [15:0] prod; } exp_t;
    exp_t sb[$];

    int               goal[N];
    int               issued[N];
    logic signed [7:0] op_a[N];
    logic signed [7:0] op_b[N];

    // Multiplier model
    int               lat = 0;
    bit               hang = 0;
    bit               spur = 0;
    bit               m_busy = 0;
    int               m_cd = 0;
    logic             m_done = 1'b0;
    logic signed [7:0] m_a, m_b;
    logic [15:0]      m_prod = '0;

    assign mul_done    = m_done | spur;
    assign mul_product = spur ? 16'h7777 : m_prod;

    mult_share_arbiter #(.NUM_REQ(N), .TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_product(rsp_product),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_done(mul_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]    = issued[i] < goal[i];
            req_a[8*i +: 8] = op_a[i];
            req_b[8*i +: 8] = op_b[i];
        end
    end

    initial for (int i = 0; i < N; i++) begin
        goal[i] = 0; issued[i] = 0; op_a[i] = '0; op_b[i] = '0;
    end

    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) issued[i] <= issued[i] + 1;

    always @(negedge clk) begin
        m_done = 1'b0;
        if (!rst_n) begin
            m_busy = 0;
        end else begin
            if (m_busy) begin
                if (m_cd == 0) begin
                    m_done = 1'b1;
                    m_prod = 16'(m_a * m_b);
                    m_busy = 0;
                end else m_cd--;
            end
            if (mul_valid && !hang) begin
                m_a = mul_a; m_b = mul_b; m_busy = 1; m_cd = lat;
            end
        end
    end

    // Response monitor plus per-cycle grant sanity
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (busy) check("ready_outside_idle", 32'(req_ready), 32'd0);
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("rsp_valid_req%0d", e.idx), 32'(rsp_valid), 32'(1 << e.idx));
                    check($sformatf("rsp_product_req%0d", e.idx), 32'(rsp_product), 32'(e.prod));
                end
            end
        end
    end

    task automatic send(input int i, input logic signed [7:0] a, input logic signed [7:0] b,
                        input logic [15:0] prod, input bit expect_rsp);
        exp_t e;
        op_a[i] = a; op_b[i] = b;
        goal[i] = goal[i] + 1;
        if (expect_rsp) begin
            e.idx = i; e.prod = prod;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        bit done_ok = 0;
        while (k < 400 && !done_ok) begin
            @(negedge clk);
            done_ok = (sb.size() == 0) && !busy;
            for (int i = 0; i < N; i++) if (issued[i] != goal[i]) done_ok = 0;
            k++;
        end
        check({name, "_drain"}, 32'(done_ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_issue(input string name);
        int k = 0;
        @(negedge clk);
        while (!mul_valid && k < 50) begin @(negedge clk); k++; end
        check({name, "_issue_seen"}, 32'(mul_valid), 32'd1);
    endtask

    initial begin
        do_reset();

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_mul_valid", 32'(mul_valid), 0);
        check("rst_rsp_product", 32'(rsp_product), 0);

        // 1: single request, cycle-level timing
        send(0, 8'sd10, 8'sd20, 16'd200, 1);
        @(negedge clk);
        check("t1_ready_same_cycle", 32'(req_ready), 32'b0001);
        @(negedge clk);
        check("t1_mul_valid", 32'(mul_valid), 1);
        check("t1_mul_a", 32'(mul_a), 32'd10);
        check("t1_mul_b", 32'(mul_b), 32'd20);
        @(negedge clk);
        check("t1_mul_valid_one_cycle", 32'(mul_valid), 0);
        @(negedge clk);
        check("t1_busy_in_resp", 32'(busy), 1);
        @(negedge clk);
        check("t1_busy_after_resp", 32'(busy), 0);
        wait_drain("t1");

        // 2: all four at once, grants 0..3
        do_reset();
        lat = 1;
        send(0, 8'sd127, 8'sd127, 16'd16129, 1);
        send(1, -8'sd5, 8'sd4, 16'hFFEC, 1);
        send(2, -8'sd128, -8'sd128, 16'd16384, 1);
        send(3, 8'sd0, -8'sd7, 16'd0, 1);
        wait_drain("t2");

        // 3: requesters 1 and 3 held valid, alternate grants
        do_reset();
        lat = 0;
        for (int r = 0; r < 3; r++) begin
            send(1, 8'sd2, 8'sd3, 16'd6, 1);
            send(3, -8'sd4, 8'sd5, 16'hFFEC, 1);
        end
        sb.delete();
        for (int r = 0; r < 3; r++) begin
            exp_t e;
            e.idx = 1; e.prod = 16'd6;    sb.push_back(e);
            e.idx = 3; e.prod = 16'hFFEC; sb.push_back(e);
        end
        wait_drain("t3");

        // 4: hung multiplier, watchdog abort
        do_reset();
        hang = 1;
        send(0, 8'sd5, 8'sd6, 16'd30, 0);
        wait_issue("t4");
        begin
            int pulses = 0;
            int first = -1;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (timeout_err) begin
                    pulses++;
                    if (first < 0) first = k;
                    check("t4_idle_after_abort", 32'(busy), 0);
                end
            end
            check("t4_timeout_pulses", 32'(pulses), 1);
            check("t4_timeout_cycle", 32'(first), 32'd33);
        end
        hang = 0;
        send(2, -8'sd7, 8'sd9, 16'hFFC1, 1);
        wait_drain("t4_recover");

        // 5: reset while in WAIT
        lat = 10;
        send(1, 8'sd11, 8'sd2, 16'd22, 0);
        wait_issue("t5");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_mul_a", 32'(mul_a), 0);
        check("t5_mul_b", 32'(mul_b), 0);
        check("t5_mul_valid", 32'(mul_valid), 0);
        check("t5_rsp", {rsp_valid, rsp_product}, 0);
        check("t5_ready_timeout", {req_ready, timeout_err}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        lat = 2;
        send(0, 8'sd3, -8'sd3, 16'hFFF7, 1);
        send(1, 8'sd11, 8'sd2, 16'd22, 1);
        wait_drain("t5");

        // 6: spurious done in IDLE and ISSUE
        lat = 3;
        @(negedge clk);
        spur = 1;
        @(negedge clk);
        spur = 0;
        check("t6_idle_ignores_done", 32'(busy), 0);
        send(3, -8'sd12, -8'sd11, 16'd132, 1);
        wait_issue("t6");
        spur = 1;
        @(negedge clk);
        spur = 0;
        check("t6_issue_to_wait", {busy, mul_valid}, 32'b10);
        wait_drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule
